chi_rxflit_buffer: RTL and testbench

Receive-side flit buffer for the CHI bridge. It accepts flits from the DUT on one CHI link channel (RSP, DAT or SNP) and issues link-layer credits so the transmitter can never overrun storage. Received flits are held in a circular buffer, and the host reads them out as 32-bit words. It is the counterpart of the TX flit RAM, which holds flits before they are driven into the DUT.

---
 rtl/chi_rxflit_buffer_if.sv | 21 ++
 rtl/chi_rxflit_buffer.sv | 48 ++++
 tb/tb_chi_rxflit_buffer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/chi_rxflit_buffer_if.sv
// chi_rxflit_buffer_if: link-side flit/credit channel plus host read/pop/error port of the RX flit buffer.
interface chi_rxflit_buffer_if #(
  parameter int FLIT_WIDTH = 128,
  parameter int DEPTH_LOG2 = 4
);
  localparam int WSEL = FLIT_WIDTH > 32 ? $clog2(FLIT_WIDTH / 32) : 1;
  logic link_active, rx_flitv, rx_lcrdv, rd_en, pop, empty, overflow_err, clear_err;
  logic [FLIT_WIDTH-1:0] rx_flit;
  logic [WSEL-1:0] rd_word;
  logic [31:0] rd_data;
  logic [DEPTH_LOG2:0] count;
  logic [3:0] credit_cnt;
  modport master (
    output link_active, rx_flitv, rx_flit, rd_en, rd_word, pop, clear_err,
    input  rx_lcrdv, rd_data, empty, count, credit_cnt, overflow_err
  );
  modport slave (
    input  link_active, rx_flitv, rx_flit, rd_en, rd_word, pop, clear_err,
    output rx_lcrdv, rd_data, empty, count, credit_cnt, overflow_err
  );
endinterface

// File: rtl/chi_rxflit_buffer.sv
// chi_rxflit_buffer: credit-managed circular buffer for received CHI flits, read out by the host as 32-bit words.
module chi_rxflit_buffer #(
  parameter int FLIT_WIDTH = 128,
  parameter int DEPTH_LOG2 = 4,
  parameter int MAX_LCRD   = 15
) (
  input logic clk,
  input logic resetn,
  chi_rxflit_buffer_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW:0] occupancy;
  logic armed, credit_ok, accept, drop, do_pop;
  // armed delays the first credit to the second edge after reset release
  always_comb begin
    occupancy = {1'b0, bus.count} + (CW + 1)'(bus.credit_cnt);
    credit_ok = armed && bus.link_active && bus.credit_cnt < 4'(MAX_LCRD) && occupancy < (CW + 1)'(DEPTH);
    accept = bus.rx_flitv && bus.credit_cnt != 4'd0 && bus.count != CW'(DEPTH);
    drop = bus.rx_flitv && !accept;
    do_pop = bus.pop && bus.count != '0;
  end
  assign bus.empty = bus.count == '0;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      armed <= 1'b0;
      bus.rx_lcrdv <= 1'b0;
      bus.credit_cnt <= '0;
      bus.count <= '0;
      bus.overflow_err <= 1'b0;
      bus.rd_data <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      armed <= 1'b1;
      bus.rx_lcrdv <= credit_ok;
      bus.credit_cnt <= bus.credit_cnt + 4'(credit_ok) - 4'(accept);
      bus.count <= bus.count + CW'(accept) - CW'(do_pop);
      bus.overflow_err <= drop || (bus.overflow_err && !bus.clear_err);
      wr_ptr <= wr_ptr + DEPTH_LOG2'(accept);
      rd_ptr <= rd_ptr + DEPTH_LOG2'(do_pop);
      if (bus.rd_en && !bus.empty) bus.rd_data <= mem[rd_ptr][{bus.rd_word, 5'd0} +: 32];
    end
  end
  always_ff @(posedge clk) if (accept) mem[wr_ptr] <= bus.rx_flit;
endmodule

// File: tb/tb_chi_rxflit_buffer.sv
// tb_chi_rxflit_buffer: directed checks of credit issue, flit storage, word readback, overflow and reset.
module tb_chi_rxflit_buffer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  chi_rxflit_buffer_if #(.FLIT_WIDTH(128), .DEPTH_LOG2(4)) bus ();
  chi_rxflit_buffer #(.FLIT_WIDTH(128), .DEPTH_LOG2(4), .MAX_LCRD(15)) dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    pulses += int'(bus.rx_lcrdv);
  endtask

  task automatic send(input logic [127:0] f);
    bus.rx_flitv = 1'b1;
    bus.rx_flit = f;
    step();
    bus.rx_flitv = 1'b0;
  endtask

  task automatic rd(input logic [1:0] w);
    bus.rd_en = 1'b1;
    bus.rd_word = w;
    step();
    bus.rd_en = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_lcrdv"}, bus.rx_lcrdv, 0);
    chk({tag, "_rd_data"}, bus.rd_data, 0);
    chk({tag, "_empty"}, bus.empty, 1);
    chk({tag, "_count"}, bus.count, 0);
    chk({tag, "_credit"}, bus.credit_cnt, 0);
    chk({tag, "_ovf"}, bus.overflow_err, 0);
  endtask

  function automatic logic [127:0] fl(input int i);
    return {32'h3000_0000 + i, 32'h2000_0000 + i, 32'h1000_0000 + i, 32'h0000_0000 + i};
  endfunction

  initial begin
    bus.link_active = 1'b1;
    bus.rx_flitv = 1'b0;
    bus.rx_flit = '0;
    bus.rd_en = 1'b0;
    bus.rd_word = '0;
    bus.pop = 1'b0;
    bus.clear_err = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    resetn = 1'b1;
    step();
    chk("first_edge_no_credit", bus.rx_lcrdv, 0);
    step();
    chk("second_edge_credit", bus.rx_lcrdv, 1);
    chk("second_edge_cnt", bus.credit_cnt, 1);
    repeat (20) step();
    chk("ramp_pulses", pulses, 15);
    chk("ramp_credit", bus.credit_cnt, 15);
    chk("ramp_lcrdv_idle", bus.rx_lcrdv, 0);

    send(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    chk("single_count", bus.count, 1);
    chk("single_empty", bus.empty, 0);
    rd(0); chk("rd_w0", bus.rd_data, 32'h4455_6677);
    rd(1); chk("rd_w1", bus.rd_data, 32'h0011_2233);
    rd(2); chk("rd_w2", bus.rd_data, 32'h89AB_CDEF);
    rd(3); chk("rd_w3", bus.rd_data, 32'h0123_4567);
    bus.pop = 1'b1; step(); bus.pop = 1'b0;
    chk("pop_empty", bus.empty, 1);
    rd(1); chk("rd_empty_hold", bus.rd_data, 32'h0123_4567);
    chk("single_credit", bus.credit_cnt, 15);

    pulses = 0;
    for (int i = 0; i < 16; i++) send(fl(i));
    repeat (3) step();
    chk("fill_extra_credit", pulses, 1);
    chk("fill_count", bus.count, 16);
    chk("fill_credit", bus.credit_cnt, 0);
    pulses = 0;
    bus.pop = 1'b1; step(); bus.pop = 1'b0;
    repeat (4) step();
    chk("pop_one_credit", pulses, 1);
    chk("pop_count", bus.count, 15);
    chk("pop_credit", bus.credit_cnt, 1);

    send(fl(16));
    chk("full_count", bus.count, 16);
    chk("full_credit", bus.credit_cnt, 0);
    send(fl(99));
    chk("ovf_set", bus.overflow_err, 1);
    chk("ovf_count", bus.count, 16);
    chk("ovf_credit", bus.credit_cnt, 0);
    bus.clear_err = 1'b1; bus.rx_flitv = 1'b1;
    step();
    bus.clear_err = 1'b0; bus.rx_flitv = 1'b0;
    chk("ovf_set_wins", bus.overflow_err, 1);
    bus.clear_err = 1'b1; step(); bus.clear_err = 1'b0;
    chk("ovf_clear", bus.overflow_err, 0);

    bus.pop = 1'b1; repeat (13) step(); bus.pop = 1'b0;
    chk("drain_count", bus.count, 3);
    repeat (16) step();
    chk("drain_credit", bus.credit_cnt, 13);
    bus.rx_flitv = 1'b1; bus.rx_flit = fl(17); bus.pop = 1'b1;
    step();
    bus.rx_flitv = 1'b0; bus.pop = 1'b0;
    chk("pushpop_count", bus.count, 3);
    rd(0); chk("pushpop_head_w0", bus.rd_data, 32'h0000_000F);
    rd(3); chk("pushpop_head_w3", bus.rd_data, 32'h3000_000F);

    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    for (int k = 0; k < 40 && bus.credit_cnt != 4'd12; k++) step();
    chk("ramp_to_12", bus.credit_cnt, 12);
    bus.link_active = 1'b0;
    for (int i = 0; i < 5; i++) send(fl(50 + i));
    repeat (3) step();
    chk("linkdown_count", bus.count, 5);
    chk("linkdown_credit", bus.credit_cnt, 7);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 chk_reset("midreset");
    @(negedge clk);
    resetn = 1'b1;
    bus.link_active = 1'b1;
    pulses = 0;
    step();
    chk("restart_no_credit", bus.rx_lcrdv, 0);
    repeat (20) step();
    chk("restart_pulses", pulses, 15);
    chk("restart_credit", bus.credit_cnt, 15);

    bus.rx_flitv = 1'b1; bus.rx_flit = fl(42); bus.pop = 1'b1;
    step();
    bus.rx_flitv = 1'b0; bus.pop = 1'b0;
    chk("first_push_pop_count", bus.count, 1);
    chk("first_push_pop_empty", bus.empty, 0);
    rd(0); chk("first_push_rd", bus.rd_data, 32'h0000_002A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
